// File: rtl/ifft_bin_sequencer_if.sv
// AXI-Stream link from the bin sequencer to the IFFT core input.
// The master drives data, valid and last; the slave returns ready.
interface ifft_bin_sequencer_if #(
    parameter int unsigned TdataW = 36
) ();
    logic [TdataW-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ifft_bin_sequencer.sv
// Double-buffered IFFT bin table: the host fills the shadow bank over the register port,
// and each trigger commits that bank and streams it as one frame of complex beats.
module ifft_bin_sequencer #(
    parameter int unsigned NFFT_LOG2 = 10,
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned NUM_CH    = 1,
    parameter int unsigned CH_W      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_wr_en,
    input  logic                      reg_rd_en,
    input  logic [CH_W+NFFT_LOG2:0]   reg_addr,
    input  logic [31:0]               reg_wr_data,
    output logic [31:0]               reg_rd_data,
    output logic                      reg_rd_valid,
    input  logic                      trig_load,
    input  logic                      mode_cont,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic                      clr_flags,
    ifft_bin_sequencer_if.master      m_axis,
    output logic                      busy,
    output logic                      active_bank,
    output logic [15:0]               frames_sent,
    output logic                      trig_overrun
);
    localparam int unsigned NBins = 2 ** NFFT_LOG2;
    localparam int unsigned NChSp = 2 ** CH_W;
    localparam int unsigned BeatW = NUM_CH * 2 * DATA_W;

    typedef logic [DATA_W-1:0] sample_t;
    typedef enum logic [1:0] {StIdle, StPrime, StStream} state_e;

    // Indexed by the full channel field; slots at or above NUM_CH are never written.
    sample_t re_mem [2][NChSp][NBins];
    sample_t im_mem [2][NChSp][NBins];

    state_e                 state_q, state_d;
    logic                   bank_q, bank_d;
    logic [NFFT_LOG2-1:0]   bin_q, bin_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [BeatW-1:0]       tdata_q, tdata_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic [15:0]            frames_q, frames_d;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;

    logic                   overrun_set;
    logic                   load;
    logic                   rd_bank;
    logic [NFFT_LOG2-1:0]   rd_bin;
    logic [BeatW-1:0]       beat;

    logic [CH_W-1:0]        host_ch;
    logic [NFFT_LOG2-1:0]   host_bin;
    logic                   host_im;
    logic                   host_ch_ok;
    logic                   shadow;
    sample_t                host_sel;
    logic                   unused_wr_data;

    assign host_ch        = reg_addr[CH_W+NFFT_LOG2 -: CH_W];
    assign host_bin       = reg_addr[NFFT_LOG2:1];
    assign host_im        = reg_addr[0];
    assign host_ch_ok     = (32'(host_ch) < NUM_CH);
    assign shadow         = ~bank_q;
    assign unused_wr_data = ^reg_wr_data;

    always_ff @(posedge clk) begin
        if (reg_wr_en && host_ch_ok) begin
            if (host_im) begin
                im_mem[shadow][host_ch][host_bin] <= reg_wr_data[DATA_W-1:0];
            end else begin
                re_mem[shadow][host_ch][host_bin] <= reg_wr_data[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        host_sel   = host_im ? im_mem[shadow][host_ch][host_bin]
                             : re_mem[shadow][host_ch][host_bin];
        rd_valid_d = reg_rd_en;
        rd_data_d  = rd_data_q;
        if (reg_rd_en) begin
            rd_data_d = host_ch_ok ? 32'(signed'(host_sel)) : '0;
        end
    end

    always_comb begin
        beat = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_enable[c]) begin
                beat[c*2*DATA_W +: 2*DATA_W] = {im_mem[rd_bank][CH_W'(c)][rd_bin],
                                                re_mem[rd_bank][CH_W'(c)][rd_bin]};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        bin_d       = bin_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        pending_d   = pending_q;
        frames_d    = frames_q;
        overrun_set = 1'b0;
        load        = 1'b0;
        rd_bank     = bank_q;
        rd_bin      = bin_q;
        unique case (state_q)
            StIdle: begin
                if (trig_load || pending_q) begin
                    bank_d    = ~bank_q;
                    bin_d     = '0;
                    state_d   = StPrime;
                    pending_d = trig_load && pending_q;
                end
            end
            StPrime: begin
                load     = 1'b1;
                tvalid_d = 1'b1;
                tlast_d  = 1'b0;
                state_d  = StStream;
            end
            StStream: begin
                if (tvalid_q && m_axis.tready) begin
                    if (tlast_q) begin
                        frames_d = frames_q + 16'd1;
                        bin_d    = '0;
                        tlast_d  = 1'b0;
                        if (pending_q) begin
                            bank_d    = ~bank_q;
                            pending_d = 1'b0;
                            load      = 1'b1;
                        end else if (mode_cont) begin
                            load = 1'b1;
                        end else begin
                            tvalid_d = 1'b0;
                            state_d  = StIdle;
                        end
                    end else begin
                        bin_d   = bin_q + NFFT_LOG2'(1);
                        tlast_d = &bin_d;
                        load    = 1'b1;
                    end
                    // Prefetch the following beat so transfers continue without bubbles.
                    rd_bank = bank_d;
                    rd_bin  = bin_d;
                end
            end
            default: state_d = StIdle;
        endcase
        // A trigger consumed at this frame boundary frees the slot for a new one.
        if (trig_load && (state_q != StIdle)) begin
            if (pending_d) begin
                overrun_set = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
        overrun_d = (overrun_q & ~clr_flags) | overrun_set;
        tdata_d   = load ? beat : tdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bank_q     <= 1'b0;
            bin_q      <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            frames_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            bin_q      <= bin_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            frames_q   <= frames_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = (state_q != StIdle) || pending_q;
    assign active_bank   = bank_q;
    assign frames_sent   = frames_q;
    assign trig_overrun  = overrun_q;
    assign reg_rd_data   = rd_data_q;
    assign reg_rd_valid  = rd_valid_q;
endmodule

// File: doc/ifft_bin_sequencer.md
Name: ifft_bin_sequencer

Overview:
- Holds the host-programmed frequency-bin table for the IFFT signal generator and streams it to the IFFT core as one frame of 2^NFFT_LOG2 complex beats per trigger.
- Generalises the single-channel load-then-send path to multiple parallel channels, configurable FFT length and sample width, double-buffered banks and a continuous-repeat mode.
- Sits between the host register bridge and trigger endpoint on one side and the IFFT core's AXI-Stream input on the other.

Parameters:
- NFFT_LOG2, 10: log2 of the FFT length; the frame is 2^NFFT_LOG2 beats.
- DATA_W, 18: width of each real or imaginary component (2..32).
- NUM_CH, 1: number of parallel channels (1..4).
- CH_W, 2: width of the channel field in the register address; must satisfy 2^CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- reg_wr_en  in  1  one-cycle register write strobe.
- reg_rd_en  in  1  one-cycle register read strobe.
- reg_addr  in  CH_W+NFFT_LOG2+1  address: {channel, bin, im_sel}. Bit 0 selects real (0) or imaginary (1).
- reg_wr_data  in  32  write data; bits [DATA_W-1:0] are used.
- reg_rd_data  out  32  readback data, sign-extended.
- reg_rd_valid  out  1  readback strobe, one cycle after reg_rd_en.
- trig_load  in  1  one-cycle pulse: commit the shadow bank and send a frame.
- mode_cont  in  1  1 selects continuous frame repeat.
- ch_enable  in  NUM_CH  per-channel enable; a disabled channel outputs zeros.
- clr_flags  in  1  clears trig_overrun.
- m_axis_tdata  out  NUM_CH*2*DATA_W  per channel c, {im, re} occupies slice c.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  asserted on the last bin of the frame.
- busy  out  1  a frame is streaming or pending.
- active_bank  out  1  index of the bank currently being streamed.
- frames_sent  out  16  count of completed frames; wraps at 2^16.
- trig_overrun  out  1  sticky; set when a trigger is lost.

Behaviour:

Storage and host access:
- Two banks. Each bank holds NUM_CH x 2^NFFT_LOG2 x {re, im}, stored as separate re and im arrays so a single component can be written without read-modify-write.
- Host writes and reads always target the shadow bank (~active_bank).
- Accesses with channel >= NUM_CH: writes are ignored; reads return 0.
- Read latency is 1 cycle. The value is sign-extended from bit DATA_W-1 to 32 bits.
- Bank contents are not cleared by reset.

Reset:
- All outputs go to 0, active_bank goes to 0, the FSM goes to IDLE.
- A reset asserted mid-frame drops tvalid on the same edge. No tlast is produced, frames_sent is not incremented, and any pending trigger is discarded.

FSM states: IDLE, PRIME, STREAM.
- IDLE, trig_load=1:
  - toggle active_bank, clear bin counter, go to PRIME.
  - A host write in the same cycle lands in the pre-toggle shadow bank, so it is included in the frame being launched.
- PRIME: one cycle for the memory read; load the output register; tvalid=1; go to STREAM.
- STREAM:
  - The beat transfers when tvalid & tready. The counter advances and the next bin is prefetched, so back-to-back beats run with no bubbles.
  - tdata, tvalid and tlast hold stable while tvalid & !tready.
  - tlast is asserted when the bin counter = 2^NFFT_LOG2-1.
- At end of frame (tlast beat transferred), frames_sent increments, then:
  - pending trigger set: toggle active_bank, clear pending, start the next frame seamlessly (no idle cycle).
  - else if mode_cont=1: restart at bin 0 from the same bank with no bubble.
  - else: tvalid=0, go to IDLE.
- trig_load in PRIME or STREAM: sets pending. If pending is already set, trig_overrun is set and the extra trigger is dropped.
- mode_cont is sampled only at frame boundaries.
- clr_flags and trig_overrun set in the same cycle: set wins.
- busy = (state != IDLE) | pending.

Data mapping:
- Per beat, slice c carries {im[c][bin], re[c][bin]}, or zero when ch_enable[c]=0.
- ch_enable is sampled at each memory read.

Test Plan:
1. NUM_CH=2, NFFT_LOG2=10, DATA_W=18, tready=1. Zero both banks, write addr ch0/bin488/re = 0x3FFFF, pulse trig_load -> 1024 beats; beat 488 ch0 re=0x3FFFF, im=0; every other field 0; tlast only on beat 1023; frames_sent=1; busy=0 afterwards; active_bank=1.
2. Same as scenario 1 with tready randomised at 50% -> identical beat sequence; tdata/tlast stable across every stall; exactly 1024 transfers.
3. Write ch1/bin3/im = 0x2ABCD, then read the same address -> reg_rd_valid one cycle later, reg_rd_data=0xFFFEABCD. Read with channel field=2 or 3 -> 0x00000000.
4. mode_cont=1 with one trigger, tready=1 -> 3 frames with no idle cycles between them; tvalid continuous. Deassert mode_cont mid-frame 3 -> stream stops after tlast of frame 3; frames_sent=3.
5. During frame 1, write the shadow bank (bin 5 re=0x100), pulse trig_load twice -> first pulse sets pending; second sets trig_overrun=1. Frame 2 follows with no bubble from the new bank, beat 5 re=0x100. clr_flags -> trig_overrun=0.
6. Assert reset at beat 300 -> tvalid=0 on the next edge; frames_sent=0; active_bank=0. A subsequent trigger streams bank 1 correctly from bin 0.
